// File: rtl/adc_scan_monitor.sv
// Round-robin serial-ADC scanner: averages 2^AVG_LOG conversions per mux channel
// and drives a hysteresis relay plus an LED bar graph from channel 0's average.
module adc_scan_monitor #(
    parameter int DATA_W   = 12,
    parameter int CLK_DIV  = 8,
    parameter int N_CH     = 4,
    parameter int AVG_LOG  = 2,
    parameter int N_LED    = 5,
    parameter int CONV_GAP = 16,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_in,
    output logic              adclk,
    output logic              cs_n,
    output logic [CH_W-1:0]   ch_sel,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic [DATA_W-1:0] avg_data,
    output logic [CH_W-1:0]   avg_ch,
    output logic              avg_valid,
    output logic              K_1,
    output logic [N_LED-1:0]  LED,
    output logic              dbg_state
);

    localparam int ACC_W    = DATA_W + AVG_LOG;
    localparam int GAP_W    = $clog2(CONV_GAP + 1);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W    = $clog2(DATA_W);
    localparam int CNT_W    = AVG_LOG + 1;
    localparam int LED_STEP = (2 ** DATA_W) / (N_LED + 1);

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  sample;
    logic               sample_vld;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   smp_cnt;
    logic               batch_done;
    logic [N_LED-1:0]   led_next;

    assign dbg_state = state;

    // Frame sequencer. Reset loads one extra gap count so the first frame starts
    // CONV_GAP cycles after the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_GAP;
            gap_cnt    <= GAP_W'(CONV_GAP);
            div_cnt    <= '0;
            bit_cnt    <= '0;
            cs_n       <= 1'b1;
            adclk      <= 1'b0;
            shreg      <= '0;
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= 1'b0;
            if (state == ST_GAP) begin
                if (gap_cnt == '0) begin
                    state   <= ST_SHIFT;
                    cs_n    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
            end else begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (!adclk) begin
                        adclk <= 1'b1;
                        shreg <= {shreg[DATA_W-2:0], ad_in};
                    end else if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        state      <= ST_GAP;
                        cs_n       <= 1'b1;
                        adclk      <= 1'b0;
                        sample     <= shreg;
                        sample_vld <= 1'b1;
                        gap_cnt    <= GAP_W'(CONV_GAP - 1);
                    end else begin
                        adclk   <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // Accumulator is wide enough for 2^AVG_LOG full-scale samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            smp_cnt    <= '0;
            batch_done <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            if (sample_vld) begin
                acc <= (smp_cnt == '0) ? ACC_W'(sample) : acc + ACC_W'(sample);
                if (smp_cnt == CNT_W'(2 ** AVG_LOG - 1)) begin
                    smp_cnt    <= '0;
                    batch_done <= 1'b1;
                end else begin
                    smp_cnt <= smp_cnt + 1'b1;
                end
            end
        end
    end

    // avg_valid is a one-cycle strobe with no back-pressure; avg_data/avg_ch
    // hold their value until the next strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avg_data  <= '0;
            avg_ch    <= '0;
            avg_valid <= 1'b0;
            ch_sel    <= '0;
        end else begin
            avg_valid <= batch_done;
            if (batch_done) begin
                avg_data <= DATA_W'(acc >> AVG_LOG);
                avg_ch   <= ch_sel;
                ch_sel   <= (ch_sel == CH_W'(N_CH - 1)) ? '0 : ch_sel + 1'b1;
            end
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < N_LED; i++) begin
            led_next[i] = (avg_data >= DATA_W'((i + 1) * LED_STEP));
        end
    end

    // Set wins over clear when the thresholds overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            K_1 <= 1'b0;
            LED <= '0;
        end else if (avg_valid && avg_ch == '0) begin
            if (avg_data >= thr_hi) begin
                K_1 <= 1'b1;
            end else if (avg_data <= thr_lo) begin
                K_1 <= 1'b0;
            end
            LED <= led_next;
        end
    end

endmodule

// File: tb/tb_adc_scan_monitor.sv
// Bench for adc_scan_monitor: serial ADC model, batch-average reference model,
// scoreboard on avg_valid, frame-shape monitor and reset scenarios.
module tb_adc_scan_monitor;

    localparam int DATA_W   = 12;
    localparam int CLK_DIV  = 2;
    localparam int N_CH     = 4;
    localparam int AVG_LOG  = 2;
    localparam int N_LED    = 5;
    localparam int CONV_GAP = 4;
    localparam int CH_W     = 2;
    localparam int NS       = 1 << AVG_LOG;
    localparam int LOW_LEN  = DATA_W * 2 * CLK_DIV;

    logic              clk;
    logic              rst_n;
    logic              ad_in;
    logic              adclk;
    logic              cs_n;
    logic [CH_W-1:0]   ch_sel;
    logic [DATA_W-1:0] thr_hi;
    logic [DATA_W-1:0] thr_lo;
    logic [DATA_W-1:0] avg_data;
    logic [CH_W-1:0]   avg_ch;
    logic              avg_valid;
    logic              K_1;
    logic [N_LED-1:0]  LED;
    logic              dbg_state;

    adc_scan_monitor #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .N_CH(N_CH),
        .AVG_LOG(AVG_LOG), .N_LED(N_LED), .CONV_GAP(CONV_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ad_in(ad_in), .adclk(adclk), .cs_n(cs_n),
        .ch_sel(ch_sel), .thr_hi(thr_hi), .thr_lo(thr_lo), .avg_data(avg_data),
        .avg_ch(avg_ch), .avg_valid(avg_valid), .K_1(K_1), .LED(LED),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_fall   = 0;
    int n_avg    = 0;

    logic [CH_W+DATA_W-1:0] exp_q[$];
    int dir_q[$];
    int batch_vals[$];
    int model_ch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_LED-1:0] bar(input int avg);
        int step;
        step = (1 << DATA_W) / (N_LED + 1);
        bar = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (avg >= (i + 1) * step) bar[i] = 1'b1;
        end
    endfunction

    // ---------------- ADC model + reference model ----------------
    initial begin
        logic [DATA_W-1:0] cur;
        int  bit_idx;
        int  sum;
        logic in_frame, p_cs, p_ad;
        ad_in = 1'b0; in_frame = 1'b0; p_cs = 1'b1; p_ad = 1'b0;
        cur = '0; bit_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                batch_vals.delete();
                exp_q.delete();
                model_ch = 0;
                ad_in = 1'b0;
            end else if (!cs_n && p_cs) begin
                cur = dir_q.size() > 0 ? DATA_W'(dir_q.pop_front()) : DATA_W'($urandom_range(0, 4095));
                chk("ch_sel_at_frame", ch_sel, model_ch);
                bit_idx = DATA_W - 1;
                ad_in = cur[bit_idx];
                in_frame = 1'b1;
                n_fall++;
            end else if (!cs_n && in_frame && p_ad && !adclk) begin
                bit_idx--;
                ad_in = cur[bit_idx];
            end else if (cs_n && !p_cs && in_frame) begin
                in_frame = 1'b0;
                batch_vals.push_back(int'(cur));
                if (batch_vals.size() == NS) begin
                    sum = 0;
                    foreach (batch_vals[i]) sum += batch_vals[i];
                    exp_q.push_back({CH_W'(model_ch), DATA_W'(sum / NS)});
                    batch_vals.delete();
                    model_ch = (model_ch + 1) % N_CH;
                end
                ad_in = 1'($urandom_range(0, 1));
            end else if (cs_n) begin
                ad_in = 1'($urandom_range(0, 1));
            end
            p_cs = cs_n;
            p_ad = adclk;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [CH_W+DATA_W-1:0] e;
        logic k1_exp;
        logic [N_LED-1:0] led_exp;
        logic k_pending;
        k1_exp = 1'b0; led_exp = '0; k_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k1_exp = 1'b0; led_exp = '0; k_pending = 1'b0;
            end else begin
                if (k_pending) begin
                    chk("K_1", K_1, k1_exp);
                    chk("LED", LED, led_exp);
                    k_pending = 1'b0;
                end
                if (avg_valid) begin
                    n_avg++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_avg_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("avg_data", avg_data, e[DATA_W-1:0]);
                        chk("avg_ch", avg_ch, e[DATA_W +: CH_W]);
                        if (e[DATA_W +: CH_W] == '0) begin
                            if (e[DATA_W-1:0] >= thr_hi) k1_exp = 1'b1;
                            else if (e[DATA_W-1:0] <= thr_lo) k1_exp = 1'b0;
                            led_exp = bar(int'(e[DATA_W-1:0]));
                        end
                        k_pending = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- frame-shape monitor ----------------
    initial begin
        int low_cnt, pulses, hi_run, gap_cnt;
        logic hi_bad, gap_bad, have_rise, p_cs, p_ad;
        low_cnt = 0; pulses = 0; hi_run = 0; gap_cnt = 0;
        hi_bad = 0; gap_bad = 0; have_rise = 0; p_cs = 1; p_ad = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                low_cnt = 0; pulses = 0; hi_run = 0; gap_cnt = 0;
                hi_bad = 0; gap_bad = 0; have_rise = 0;
            end else if (!cs_n) begin
                if (p_cs) begin
                    if (have_rise) chk("gap_len", gap_cnt + (gap_bad ? 1000 : 0), CONV_GAP);
                    low_cnt = 0; pulses = 0; hi_run = 0; hi_bad = 0;
                end
                low_cnt++;
                if (adclk) begin
                    if (!p_ad) pulses++;
                    hi_run++;
                end else begin
                    if (p_ad && hi_run != CLK_DIV) hi_bad = 1;
                    hi_run = 0;
                end
            end else begin
                if (!p_cs) begin
                    if (p_ad && hi_run != CLK_DIV) hi_bad = 1;
                    chk("cs_n_low_len", low_cnt, LOW_LEN);
                    chk("adclk_pulses", pulses, DATA_W);
                    chk("adclk_high_len_bad", hi_bad, 0);
                    have_rise = 1; gap_cnt = 0; gap_bad = 0;
                end
                gap_cnt++;
                if (adclk) gap_bad = 1;
            end
            p_cs = cs_n;
            p_ad = adclk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_fall();
        int start;
        start = n_fall;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_fall != start) return;
        end
        chk("wait_fall_timeout", 0, 1);
    endtask

    task automatic measure_fall(output int k);
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (cs_n === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_avg(input int target);
        for (int i = 0; i < 20000 && n_avg < target; i++) @(negedge clk);
        chk("avg_count_reached", n_avg >= target, 1);
    endtask

    // ---------------- main sequence ----------------
    int ch0_tab [8][4];

    initial begin
        int k;
        int found;
        rst_n = 1'b0;
        thr_hi = 12'd3000;
        thr_lo = 12'd1000;
        ch0_tab = '{'{'hA5C, 'hA5C, 'hA5C, 'hA5C}, '{100, 101, 102, 103},
                    '{2999, 3000, 3001, 3000}, '{1998, 2002, 2000, 2001},
                    '{1000, 1001, 999, 1003}, '{681, 681, 681, 683},
                    '{2046, 2046, 2046, 2046}, '{4095, 4095, 4095, 4095}};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int s = 0; s < NS; s++) begin
                    if (c == 0) dir_q.push_back(ch0_tab[r][s]);
                    else if (c == 1 && r == 1) dir_q.push_back(4000);
                    else dir_q.push_back(int'($urandom_range(0, 4095)));
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_adclk", adclk, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_avg_data", avg_data, 0);
        chk("rst_avg_ch", avg_ch, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_K_1", K_1, 0);
        chk("rst_LED", LED, 0);
        chk("rst_state_gap", dbg_state, 0);
        #1 rst_n = 1'b1;
        // k counts edges starting with the first one out of reset
        measure_fall(k);
        chk("first_fall_delay", k, CONV_GAP + 1);

        // 32 directed batches plus one random channel-0 batch
        wait_avg(33);

        found = 0;
        for (int t = 0; t < 8 && found == 0; t++) begin
            wait_fall();
            if (batch_vals.size() == 3) found = 1;
        end
        chk("mid_reset_setup", found, 1);
        repeat (25) @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_adclk", adclk, 0);
        chk("mid_rst_ch_sel", ch_sel, 0);
        chk("mid_rst_avg_valid", avg_valid, 0);
        dir_q.push_back(200); dir_q.push_back(200);
        dir_q.push_back(200); dir_q.push_back(204);
        #1 rst_n = 1'b1;
        measure_fall(k);
        chk("post_reset_fall_delay", k, CONV_GAP + 1);

        for (int f = 0; f < 48; f++) begin
            wait_fall();
            if (f % 4 == 0) begin
                thr_hi = DATA_W'($urandom_range(0, 4095));
                thr_lo = DATA_W'($urandom_range(0, 4095));
            end
        end
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
